ysyx_22040125_dmem_resp: RTL and testbench
==========================================

YSYX_22040125_DMEM_RESP -- requirements
Module: ysyx_22040125_dmem_resp

Interface
REQ-001 SHALL have parameter BASE, default 64'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 512, number of 64-bit storage words (power of two).
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept edge to rsp_valid high; legal range 1..15.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port req_valid  in  1  requester presents a transaction.
REQ-007 SHALL have port req_ready  out  1  responder can accept; high only in IDLE.
REQ-008 SHALL have port req_wen  in  1  1=store, 0=load.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_size  in  2  0=byte, 1=half, 2=word, 3=double.
REQ-011 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port req_wdata  in  64  store data, right-aligned (bits [8*2^size-1:0] used).
REQ-013 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 64 (extended load data; 0 for stores), rsp_err out 1 (misaligned or out-of-range).

Function
REQ-014 SHALL run FSM IDLE -> BUSY -> RESP -> IDLE; accept = req_valid && req_ready.
REQ-015 SHALL on accept in IDLE latch request, load counter with LATENCY-1, enter BUSY (RESP directly if LATENCY=1).
REQ-016 SHALL decrement counter in BUSY, enter RESP when counter is 0; rsp_valid high exactly LATENCY cycles after accept edge.
REQ-017 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready; return to IDLE on the handshake edge.
REQ-018 SHALL ignore req_valid outside IDLE; exactly one transaction outstanding.
REQ-019 SHALL flag error when addr not aligned to 2^size, or (addr-BASE) >= DEPTH*8, or addr < BASE.
REQ-020 SHALL perform stores on the accept edge: only lanes addr[2:0]..addr[2:0]+2^size-1 of word (addr-BASE)>>3 modified; no write on error.
REQ-021 SHALL capture load data on accept edge: extract lane at addr[2:0], extend per req_unsigned to 64 bits; rsp_rdata=0 on error or store.
REQ-022 SHALL treat req_size=3 as unextended 64-bit regardless of req_unsigned.
REQ-023 SHALL make a load issued after a store to same address return the stored value (write precedes subsequent accept).
REQ-024 SHALL accept a new request the cycle after a response handshake; peak rate one transaction per LATENCY+1 cycles.

Reset
REQ-025 SHALL on rst force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready 0 while rst high, 1 the following cycle.
REQ-026 SHALL abandon any in-flight transaction on rst (no response); a store already committed on its accept edge remains; storage contents not reset.

Structure
REQ-027 SHALL place size encodings, FSM state encoding and alignment-mask constants in shared package ysyx_22040125_mem_pkg.
REQ-028 SHALL implement lane extract/extend and store byte-mask/merge in combinational sub-module ysyx_22040125_lane_align.

Verification
REQ-029 SHALL cover: store double 64'h1122334455667788 at 0x80000008, then load double same addr -> rsp_rdata 64'h1122334455667788, rsp_err 0, rsp_valid 2 cycles after each accept.
REQ-030 SHALL cover: store byte 8'hF0 at 0x80000009, load byte signed -> 64'hFFFFFFFFFFFFFFF0; load byte unsigned -> 64'h00000000000000F0; load double 0x80000008 -> 64'h112233445566F088.
REQ-031 SHALL cover: load word at 0x80000002 -> rsp_err 1, rsp_rdata 0; store half at 0x80001000 (DEPTH=512) -> rsp_err 1, memory unchanged.
REQ-032 SHALL cover: hold rsp_ready low 5 cycles in RESP with req_valid high -> rsp_valid/rsp_rdata stable, req_ready 0, no second accept.
REQ-033 SHALL cover: assert rst during BUSY -> next cycle rsp_valid 0, req_ready 0, then 1; no response for aborted request.

Source files
------------

// File: rtl/ysyx_22040125_mem_pkg.sv
// Shared encodings for the data-memory responder:
// access sizes, FSM states and alignment helpers.
package ysyx_22040125_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [2:0] MASK_B = 3'b000;
  localparam logic [2:0] MASK_H = 3'b001;
  localparam logic [2:0] MASK_W = 3'b011;
  localparam logic [2:0] MASK_D = 3'b111;

  function automatic logic [2:0] align_mask(
    input logic [1:0] sz
  );
    logic [2:0] m;
    unique case (1'b1)
      (sz == SZ_B): m = MASK_B;
      (sz == SZ_H): m = MASK_H;
      (sz == SZ_W): m = MASK_W;
      default:      m = MASK_D;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] byte_en(
    input logic [1:0] sz
  );
    logic [7:0] b;
    unique case (1'b1)
      (sz == SZ_B): b = 8'h01;
      (sz == SZ_H): b = 8'h03;
      (sz == SZ_W): b = 8'h0F;
      default:      b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ysyx_22040125_lane_align.sv
// Byte-lane alignment: load extract/extend and
// store byte-mask merge into a 64-bit word.
module ysyx_22040125_lane_align
  import ysyx_22040125_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  off,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  input  logic [63:0] word,
  output logic [63:0] rdata,
  output logic [63:0] merged
);

  logic [5:0]  sh;
  logic [63:0] lane;
  logic [63:0] wsh;
  logic [63:0] bmask;
  logic [7:0]  ben;

  assign sh = {off, 3'b000};

  always_comb begin
    lane = word >> sh;
    rdata = lane;
    unique case (1'b1)
      (size == SZ_B):
        rdata = is_unsigned ? {56'd0, lane[7:0]}
                            : {{56{lane[7]}}, lane[7:0]};
      (size == SZ_H):
        rdata = is_unsigned ? {48'd0, lane[15:0]}
                            : {{48{lane[15]}}, lane[15:0]};
      (size == SZ_W):
        rdata = is_unsigned ? {32'd0, lane[31:0]}
                            : {{32{lane[31]}}, lane[31:0]};
      default: rdata = lane;
    endcase
    // lanes shifted past byte 7 only occur on misaligned (rejected) stores
    ben = byte_en(size) << off;
    for (int i = 0; i < 8; i++) begin
      bmask[8*i +: 8] = {8{ben[i]}};
    end
    wsh = wdata << sh;
    merged = (word & ~bmask) | (wsh & bmask);
  end

endmodule

// File: rtl/ysyx_22040125_dmem_resp.sv
// Single-outstanding data-memory responder with
// fixed latency and valid/ready response hold.
module ysyx_22040125_dmem_resp
  import ysyx_22040125_mem_pkg::*;
#(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          DEPTH   = 512,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IW       = $clog2(DEPTH);
  localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] mem [DEPTH];

  logic [63:0] addr64;
  logic [63:0] offs;
  logic [IW-1:0] idx;
  logic        mis;
  logic        oor;
  logic        err;
  logic        accept;
  logic [63:0] word;
  logic [63:0] ld;
  logic [63:0] merged;

  assign addr64 = {32'd0, req_addr};
  assign offs   = addr64 - BASE;
  assign idx    = offs[IW+2:3];
  assign mis    = |(req_addr[2:0] & align_mask(req_size));
  assign oor    = (addr64 < BASE) || (offs >= SPAN);
  assign err    = mis | oor;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign word      = mem[idx];

  ysyx_22040125_lane_align u_lane (
    .size        (req_size),
    .off         (req_addr[2:0]),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .word        (word),
    .rdata       (ld),
    .merged      (merged)
  );

  // storage is not reset; a store commits on its own accept edge
  always_ff @(posedge clk) begin
    if (accept && req_wen && !err) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rsp_rdata <= (req_wen || err) ? 64'd0 : ld;
        rsp_err   <= err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040125_dmem_resp.sv
// Scoreboard bench for the data-memory responder:
// directed scenarios plus randomized traffic vs a byte-array model.
module tb_ysyx_22040125_dmem_resp;

  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam logic [31:0] BASE32 = 32'h8000_0000;
  localparam int          DEPTH  = 512;
  localparam int          LAT    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  ysyx_22040125_dmem_resp #(
    .BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd;
    logic        er;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mdl [0:255];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rsp_ready = hold ? 1'b0 : ($urandom % 3 != 0);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, plain arithmetic
  task automatic model(input bit wen, input logic [31:0] a,
                       input logic [1:0] sz, input bit uns,
                       input logic [63:0] wd,
                       output logic [63:0] rd, output bit er);
    longint unsigned n  = 64'd1 << sz;
    longint unsigned ad = {32'd0, a};
    longint unsigned off;
    er = (ad % n != 0) || (ad < BASE) || (ad - BASE >= DEPTH * 8);
    rd = 64'd0;
    if (!er) begin
      off = ad - BASE;
      for (int i = 0; i < int'(n); i++) begin
        if (wen) mdl[off + i] = wd[8*i +: 8];
        else rd[8*i +: 8] = mdl[off + i];
      end
      if (!wen && sz != 2'd3 && !uns && rd[8*n-1]) begin
        for (int i = int'(n); i < 8; i++) rd[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic issue(input bit wen, input logic [31:0] a,
                       input logic [1:0] sz, input bit uns,
                       input logic [63:0] wd, input bit push,
                       input bit lit, input logic [63:0] lrd,
                       input bit lerr, input bit keep);
    logic [63:0] mrd;
    bit          mer;
    exp_t        e;
    int          n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen = wen;
    req_addr = a;
    req_size = sz;
    req_unsigned = uns;
    req_wdata = wd;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=0 required=1");
      req_valid = 1'b0;
      return;
    end
    model(wen, a, sz, uns, wd, mrd, mer);
    @(posedge clk);
    @(negedge clk);
    if (push) begin
      e.rd = lit ? lrd : mrd;
      e.er = lit ? lerr : mer;
      e.acc = cyc;
      sbq.push_back(e);
    end
    if (keep) begin
      req_wen = 1'b1;
      req_addr = BASE32 + 32'h10;
      req_size = 2'd3;
      req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0 || !req_ready) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
    end
  endtask

  // Monitor: compares each response handshake against the queue head
  logic        prev_valid = 1'b0;
  logic [63:0] prev_rd = 64'd0;
  logic        prev_er = 1'b0;
  exp_t        h;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid) begin
        chk("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
        if (!prev_valid) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL spurious_rsp got=1 required=0");
          end else if (cyc - sbq[0].acc != LAT) begin
            errors++;
            $display("FAIL latency got=%0d required=%0d",
                     cyc - sbq[0].acc, LAT);
          end
        end else begin
          chk("hold_rdata", rsp_rdata, prev_rd);
          chk("hold_err", {63'd0, rsp_err}, {63'd0, prev_er});
        end
        if (rsp_ready && sbq.size() != 0) begin
          h = sbq.pop_front();
          chk("rsp_rdata", rsp_rdata, h.rd);
          chk("rsp_err", {63'd0, rsp_err}, {63'd0, h.er});
        end
      end
      prev_valid = rsp_valid && !rsp_ready;
      prev_rd = rsp_rdata;
      prev_er = rsp_err;
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] off;
    logic [1:0]  sz;
    int          r;

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

    for (int w = 0; w < 32; w++) begin
      issue(1, BASE32 + 32'(8 * w), 2'd3, 0, {$urandom, $urandom},
            1, 0, 0, 0, 0);
    end

    issue(1, 32'h8000_0008, 2'd3, 0, 64'h1122334455667788,
          1, 1, 64'd0, 0, 0);
    issue(0, 32'h8000_0008, 2'd3, 0, 64'd0,
          1, 1, 64'h1122334455667788, 0, 0);
    issue(1, 32'h8000_0009, 2'd0, 0, 64'h0000_0000_0000_00F0,
          1, 1, 64'd0, 0, 0);
    issue(0, 32'h8000_0009, 2'd0, 0, 64'd0,
          1, 1, 64'hFFFFFFFFFFFFFFF0, 0, 0);
    issue(0, 32'h8000_0009, 2'd0, 1, 64'd0,
          1, 1, 64'h00000000000000F0, 0, 0);
    issue(0, 32'h8000_0008, 2'd3, 0, 64'd0,
          1, 1, 64'h112233445566F088, 0, 0);
    issue(0, 32'h8000_0002, 2'd2, 0, 64'd0,
          1, 1, 64'd0, 1, 0);
    issue(1, 32'h8000_1000, 2'd1, 0, 64'h0000_0000_0000_ABCD,
          1, 1, 64'd0, 1, 0);
    issue(0, 32'h8000_0000, 2'd3, 0, 64'd0, 1, 0, 0, 0, 0);

    drain();
    hold = 1'b1;
    issue(0, 32'h8000_0008, 2'd3, 0, 64'd0,
          1, 1, 64'h112233445566F088, 0, 1);
    repeat (LAT + 5) @(negedge clk);
    chk("held_valid", {63'd0, rsp_valid}, 64'd1);
    req_valid = 1'b0;
    hold = 1'b0;
    issue(0, 32'h8000_0010, 2'd3, 0, 64'd0, 1, 0, 0, 0, 0);

    drain();
    issue(1, 32'h8000_0018, 2'd3, 0, 64'hCAFE_F00D_1234_5678,
          0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("abort_req_ready", {63'd0, req_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", {63'd0, req_ready}, 64'd1);
    chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    issue(0, 32'h8000_0018, 2'd3, 0, 64'd0,
          1, 1, 64'hCAFE_F00D_1234_5678, 0, 0);

    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom % 4);
      r = int'($urandom % 100);
      if (r < 85) begin
        off = $urandom % 256;
        if ($urandom % 4 != 0) off = off & ~((32'd1 << sz) - 32'd1);
        a = BASE32 + off;
      end else if (r < 92) begin
        a = BASE32 + 32'h1000 + ($urandom % 64);
      end else if (r < 97) begin
        a = BASE32 - 32'd1 - ($urandom % 64);
      end else begin
        a = 32'h0000_1000;
      end
      issue(1'($urandom % 2), a, sz, 1'($urandom % 2),
            {$urandom, $urandom}, 1, 0, 0, 0, 0);
    end

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
